// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered byte-serial RS-232 transmitter.
// Host pushes bytes into a circular FIFO; the FSM pops one byte per frame and
// serialises it LSB first, each line bit held for RATIO = CLK_HZ/BAUD cycles.
// Default frame is 8N1. Define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (8E1).
// All outputs are registered; reset is synchronous and active-high.
module uart_tx #(
    parameter int CLK_HZ          = 500000000,
    parameter int BAUD            = 9600,
    parameter int PRESCALER_BITS  = 16,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       push,
    output logic       serial_out,
    output logic       busy,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       error
);

    localparam int RATIO = CLK_HZ / BAUD;
    localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
    localparam logic [PRESCALER_BITS-1:0] LAST_TICK = PRESCALER_BITS'(RATIO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers (extra MSB is the wrap bit)
    // ------------------------------------------------------------------
    logic [7:0]                 r_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2:0]   r_wr_ptr;
    logic [FIFO_DEPTH_LOG2:0]   r_rd_ptr;
    logic                       r_fifo_full;
    logic                       r_fifo_empty;
    logic                       r_error;

    logic [FIFO_DEPTH_LOG2:0]   w_wr_ptr_nxt;
    logic [FIFO_DEPTH_LOG2:0]   w_rd_ptr_nxt;
    logic                       w_push_ok;
    logic                       w_pop;
    logic [7:0]                 w_head;

    // ------------------------------------------------------------------
    // Transmit FSM state
    // ------------------------------------------------------------------
    state_t                     r_state;
    logic [PRESCALER_BITS-1:0]  r_cnt;
    logic [2:0]                 r_idx;
    logic [7:0]                 r_shift;
    logic                       r_serial;
    logic                       r_busy;
`ifdef UART_TX_PARITY_EN
    logic                       r_parity;
`endif

    // A push is judged only against the registered full flag, so a pop in
    // the same cycle never rescues a push into a full FIFO.
    assign w_push_ok    = push & ~r_fifo_full;
    // The FSM pops only from IDLE, using the registered empty flag; this is
    // what makes a push into an empty idle FIFO start the line 2 cycles later.
    assign w_pop        = (r_state == S_IDLE) & ~r_fifo_empty;
    assign w_head       = r_mem[r_rd_ptr[FIFO_DEPTH_LOG2-1:0]];
    assign w_wr_ptr_nxt = r_wr_ptr + {{FIFO_DEPTH_LOG2{1'b0}}, w_push_ok};
    assign w_rd_ptr_nxt = r_rd_ptr + {{FIFO_DEPTH_LOG2{1'b0}}, w_pop};

    // Write accepted bytes into the FIFO storage (contents need no reset).
    always_ff @(posedge CLK) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= data_in;
        end
    end

    // Advance pointers and register full/empty from the post-update pointers;
    // overflow is sticky until reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_empty <= 1'b1;
            r_fifo_full  <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_fifo_empty <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
            r_fifo_full  <= (w_wr_ptr_nxt[FIFO_DEPTH_LOG2] != w_rd_ptr_nxt[FIFO_DEPTH_LOG2]) &&
                            (w_wr_ptr_nxt[FIFO_DEPTH_LOG2-1:0] == w_rd_ptr_nxt[FIFO_DEPTH_LOG2-1:0]);
            if (push && r_fifo_full) begin
                r_error <= 1'b1;
            end
        end
    end

    // Frame sequencer: the line value for the next bit is registered on the
    // same edge that changes state, so serial_out and busy track the state.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_serial <= 1'b1;
            r_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_serial <= 1'b1;
                    r_busy   <= 1'b0;
                    r_cnt    <= '0;
                    r_idx    <= '0;
                    if (w_pop) begin
                        r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_head;
`endif
                        r_state  <= S_START;
                        r_serial <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == LAST_TICK) begin
                        r_cnt    <= '0;
                        r_idx    <= '0;
                        r_state  <= S_DATA;
                        r_serial <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt + PRESCALER_BITS'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == LAST_TICK) begin
                        r_cnt <= '0;
                        if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state  <= S_PARITY;
                            r_serial <= r_parity;
`else
                            r_state  <= S_STOP;
                            r_serial <= 1'b1;
`endif
                        end else begin
                            r_idx    <= r_idx + 3'd1;
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_serial <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + PRESCALER_BITS'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (r_cnt == LAST_TICK) begin
                        r_cnt    <= '0;
                        r_state  <= S_STOP;
                        r_serial <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + PRESCALER_BITS'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (r_cnt == LAST_TICK) begin
                        r_cnt    <= '0;
                        r_state  <= S_IDLE;
                        r_serial <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + PRESCALER_BITS'(1);
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_serial <= 1'b1;
                    r_busy   <= 1'b0;
                    r_cnt    <= '0;
                end
            endcase
        end
    end

    assign serial_out = r_serial;
    assign busy       = r_busy;
    assign fifo_full  = r_fifo_full;
    assign fifo_empty = r_fifo_empty;
    assign error      = r_error;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx at RATIO = 10.
// The stimulus side keeps a queue-level model of the FIFO and of when the
// transmitter is free, and pushes {byte, expected start cycle} for every frame
// it predicts. An independent line monitor detects start edges on serial_out,
// pops the scoreboard and compares every cycle of the frame against the bit
// pattern built from the byte.
module tb_uart_tx;

    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int RATIO  = CLK_HZ / BAUD;
    localparam int DL2    = 4;
    localparam int DEPTH  = 2 ** DL2;
`ifdef UART_TX_PARITY_EN
    localparam int FB     = 11;
`else
    localparam int FB     = 10;
`endif

    typedef struct {
        logic [7:0] b;
        int         start;
    } exp_t;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       push = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       serial_out, busy, fifo_full, fifo_empty, error;

    uart_tx #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .PRESCALER_BITS(16), .FIFO_DEPTH_LOG2(DL2)
    ) dut (
        .CLK(CLK), .reset(reset), .data_in(data_in), .push(push),
        .serial_out(serial_out), .busy(busy), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .error(error)
    );

    always #5 CLK = ~CLK;

    int gcyc = 0;
    always @(posedge CLK) gcyc <= gcyc + 1;

    // model state
    logic [7:0] mq[$];
    exp_t       exp_q[$];
    int         idle_cycle = 0;
    int         last_pop = -1;
    bit         m_err = 1'b0;
    bit         in_frame = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, gcyc);
        end
    endtask

    function automatic bit m_busy(input int x);
        return (x > last_pop) && (x < idle_cycle);
    endfunction

    task automatic check_flags();
        chk("fifo_empty", int'(fifo_empty), int'(mq.size() == 0));
        chk("fifo_full", int'(fifo_full), int'(mq.size() == DEPTH));
        chk("busy", int'(busy), int'(m_busy(gcyc)));
        chk("error", int'(error), int'(m_err));
    endtask

    // One clock cycle of stimulus; the model decides acceptance and pops for
    // the current cycle, then the flags of the following cycle are checked.
    task automatic tick(input bit p, input logic [7:0] d);
        int   c;
        bit   acc;
        bit   pop;
        exp_t e;
        c       = gcyc;
        push    = p;
        data_in = d;
        acc = p && (mq.size() < DEPTH);
        pop = (c >= idle_cycle) && (mq.size() > 0);
        if (p && !acc) m_err = 1'b1;
        if (pop) begin
            e.b   = mq.pop_front();
            e.start = c + 1;
            exp_q.push_back(e);
            last_pop   = c;
            idle_cycle = c + 1 + FB * RATIO;
        end
        if (acc) mq.push_back(d);
        @(posedge CLK);
        #1;
        push = 1'b0;
        check_flags();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        push  = 1'b0;
        @(posedge CLK);
        #1;
        reset = 1'b0;
        mq.delete();
        exp_q.delete();
        m_err      = 1'b0;
        idle_cycle = gcyc;
        last_pop   = -1;
        check_flags();
        chk("serial_after_reset", int'(serial_out), 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || mq.size() > 0 || in_frame || gcyc < idle_cycle) && n < 20000) begin
            tick(1'b0, 8'h00);
            n++;
        end
        chk("drain_within_bound", int'(n < 20000), 1);
    endtask

    // Line monitor: decoupled from stimulus, driven only by serial_out.
    initial begin
        exp_t        e;
        logic [FB-1:0] bits;
        int          k;
        int          bad_k;
        bit          bad;
        bit          unexp;
        k = 0; bad_k = 0; bad = 1'b0; unexp = 1'b0; bits = '1;
        forever begin
            @(negedge CLK);
            if (reset) begin
                in_frame = 1'b0;
                continue;
            end
            if (!in_frame && serial_out !== 1'b1) begin
                in_frame = 1'b1;
                k = 0;
                bad = 1'b0;
                unexp = 1'b0;
                if (exp_q.size() == 0) begin
                    unexp = 1'b1;
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_frame: start edge at cycle %0d, none expected", gcyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("start_cycle", gcyc, e.start);
`ifdef UART_TX_PARITY_EN
                    bits = {1'b1, ^e.b, e.b, 1'b0};
`else
                    bits = {1'b1, e.b, 1'b0};
`endif
                end
            end
            if (in_frame) begin
                if (!unexp && serial_out !== bits[k / RATIO]) begin
                    if (!bad) bad_k = k;
                    bad = 1'b1;
                end
                k++;
                if (k == FB * RATIO) begin
                    in_frame = 1'b0;
                    if (!unexp) begin
                        n_chk++;
                        if (bad) begin
                            n_fail++;
                            $display("FAIL frame_bits: byte %02h wrong line at frame offset %0d (bit %0d), expected pattern %b",
                                     e.b, bad_k, bad_k / RATIO, bits);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int c0;
        // reset state
        repeat (2) @(posedge CLK);
        #1;
        check_flags();
        chk("serial_reset", int'(serial_out), 1);
        reset = 1'b0;

        // single byte 0xA5
        tick(1'b1, 8'hA5);
        drain();

        // back-to-back 0x00..0x0F
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(i));
        drain();
        chk("b2b_no_error", int'(error), 0);

        // overflow: 18 consecutive pushes from idle
        for (int i = 0; i < 18; i++) tick(1'b1, 8'(8'h40 + i));
        chk("ovf_error", int'(error), 1);
        drain();
        do_reset();

        // reset during data bit 3 of 0xFF with 3 bytes queued
        c0 = gcyc;
        tick(1'b1, 8'hFF);
        tick(1'b1, 8'h11);
        tick(1'b1, 8'h22);
        tick(1'b1, 8'h33);
        while (gcyc < c0 + 2 + RATIO * 4 + 3) tick(1'b0, 8'h00);
        do_reset();
        chk("midframe_empty", int'(fifo_empty), 1);
        repeat (300) tick(1'b0, 8'h00);

        // random heavy traffic (overflows likely), then reset
        for (int i = 0; i < 700; i++) tick(($urandom % 3) == 0, 8'($urandom));
        do_reset();

        // random light traffic, fully drained
        for (int i = 0; i < 1500; i++) tick(($urandom % 60) == 0, 8'($urandom));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
